// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-style control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// instruction legality checking, memory wait timeout and sticky trap flags.
//
// state  | meaning
// FETCH  | read instruction; on mem_ready latch IR and advance PC
// DECODE | check opcode/funct legality
// EXEC   | drive ALU controls, resolve branch/jump
// MEM    | load/store access, wait for mem_ready
// WB     | register write-back for one cycle
// TRAP   | fault; all strobes off until rst
module multicycle_control_unit #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int EN_JUMP     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
    output logic               trap,
    output logic               timeout
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           cur_state, nxt_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             trap_q, timeout_q, timeout_set;
    logic             is_r, is_i, is_ld, is_st, is_br, is_jal, legal;
    logic [3:0]       arith_op, alu4;
    logic             wait_expired;
    logic             mem_read_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, mem_to_reg_c;

    // Instruction class, legality and funct-based ALU code
    always_comb begin
        is_r     = (opcode == OP_R);
        is_i     = (opcode == OP_I);
        is_ld    = (opcode == OP_LD);
        is_st    = (opcode == OP_ST);
        is_br    = (opcode == OP_BR);
        is_jal   = (EN_JUMP != 0) && (opcode == OP_JAL);
        legal    = 1'b0;
        arith_op = ALU_ADD;
        if (is_r) begin
            legal = (funct3 != 3'b011) &&
                    ((funct7 == 7'b0) ||
                     ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        end else if (is_i) begin
            legal = (funct3 != 3'b011) &&
                    !((funct3 == 3'b001) && (funct7 != 7'b0)) &&
                    !((funct3 == 3'b101) && (funct7 != 7'b0) && (funct7 != F7_ALT));
        end else if (is_ld || is_st) begin
            legal = (funct3 == 3'b010);
        end else if (is_br) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        end else if (is_jal) begin
            legal = 1'b1;
        end
        case (funct3)
            3'b000:  arith_op = (is_r && (funct7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            3'b111:  arith_op = ALU_AND;
            default: arith_op = ALU_ADD;
        endcase
    end

    assign wait_expired = (wait_cnt == CNT_LAST) && !mem_ready;

    // Next-state and datapath strobe decode
    always_comb begin
        nxt_state    = cur_state;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu4         = ALU_ADD;
        timeout_set  = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'd2;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    nxt_state  = S_DECODE;
                end else if (wait_expired) begin
                    nxt_state   = S_TRAP;
                    timeout_set = 1'b1;
                end
            end
            S_DECODE: nxt_state = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_r) begin
                    alu_src_a = 1'b1;
                    alu4      = arith_op;
                    nxt_state = S_WB;
                end else if (is_i) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd1;
                    alu4      = arith_op;
                    nxt_state = S_WB;
                end else if (is_ld || is_st) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd1;
                    nxt_state = S_MEM;
                end else if (is_br) begin
                    alu_src_a  = 1'b1;
                    alu4       = ALU_SUB;
                    pc_write_c = (funct3 == 3'b000) ? zero : !zero;
                    nxt_state  = S_FETCH;
                end else if (is_jal) begin
                    pc_write_c = 1'b1;
                    nxt_state  = S_WB;
                end else begin
                    nxt_state = S_TRAP;
                end
            end
            S_MEM: begin
                mem_read_c  = is_ld;
                mem_write_c = !is_ld;
                if (mem_ready) begin
                    nxt_state = is_ld ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    nxt_state   = S_TRAP;
                    timeout_set = 1'b1;
                end
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = is_ld;
                nxt_state    = S_FETCH;
            end
            S_TRAP:  nxt_state = S_TRAP;
            default: nxt_state = S_TRAP;
        endcase
    end

    // State register, memory wait counter and sticky fault flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
            trap_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if ((nxt_state != cur_state) && ((nxt_state == S_FETCH) || (nxt_state == S_MEM)))
                wait_cnt <= '0;
            else if (((cur_state == S_FETCH) || (cur_state == S_MEM)) && !mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            trap_q    <= trap_q | (nxt_state == S_TRAP);
            timeout_q <= timeout_q | timeout_set;
        end
    end

    // Strobes are forced low while reset is held
    assign mem_read   = mem_read_c   & ~rst;
    assign mem_write  = mem_write_c  & ~rst;
    assign ir_write   = ir_write_c   & ~rst;
    assign pc_write   = pc_write_c   & ~rst;
    assign reg_write  = reg_write_c  & ~rst;
    assign mem_to_reg = mem_to_reg_c & ~rst;
    assign alu_op     = ALUOP_W'(alu4);
    assign state      = cur_state;
    assign trap       = trap_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_control_unit;

    localparam int AW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode, funct7;
    logic [2:0]    funct3;
    logic          zero, mem_ready;
    logic          mem_read, mem_write, ir_write, pc_write, reg_write, mem_to_reg;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [AW-1:0] alu_op;
    logic [2:0]    state;
    logic          trap, timeout;

    int total = 0;
    int bad   = 0;

    typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_BAD} cls_t;

    multicycle_control_unit #(.ALUOP_W(AW), .MEM_TIMEOUT(TO), .EN_JUMP(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .trap(trap), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {mem_read, mem_write, ir_write, pc_write, reg_write, mem_to_reg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level legality: which instruction does this encode, if any
    function automatic cls_t ref_class(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        case (op)
            7'b0110011: begin
                if (f3 == 3) return C_BAD;
                if (f7 == 7'h00) return C_R;
                if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) return C_R;
                return C_BAD;
            end
            7'b0010011: begin
                if (f3 == 3) return C_BAD;
                if (f3 == 1 && f7 != 7'h00) return C_BAD;
                if (f3 == 5 && f7 != 7'h00 && f7 != 7'h20) return C_BAD;
                return C_I;
            end
            7'b0000011: return (f3 == 2) ? C_LD : C_BAD;
            7'b0100011: return (f3 == 2) ? C_ST : C_BAD;
            7'b1100011: return (f3 <= 1) ? C_BR : C_BAD;
            7'b1101111: return C_JAL;
            default:    return C_BAD;
        endcase
    endfunction

    // ALU code by mnemonic: add 0 sub 1 and 2 or 3 xor 4 sll 5 srl 6 sra 7 slt 8
    function automatic int ref_alu(input cls_t c, input logic [2:0] f3, input logic [6:0] f7);
        if (c == C_BR) return 1;
        if (c != C_R && c != C_I) return 0;
        case (f3)
            3'd0: return (c == C_R && f7 == 7'h20) ? 1 : 0;
            3'd1: return 5;
            3'd2: return 8;
            3'd4: return 4;
            3'd5: return (f7 == 7'h20) ? 7 : 6;
            3'd6: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("rst/state", state, 0);
        chk("rst/trap", trap, 0);
        chk("rst/timeout", timeout, 0);
        chk("rst/strobes", strobes(), 6'b000000);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst/mem_read_resume", strobes(), 6'b100000);
    endtask

    task automatic expect_trap(input string nm, input bit tmo);
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk({nm, "/trap_state"}, state, 5);
            chk({nm, "/trap_flag"}, trap, 1);
            chk({nm, "/trap_strobes"}, strobes(), 6'b000000);
            if (tmo) chk({nm, "/timeout"}, timeout, 1);
            tick();
        end
        do_reset();
    endtask

    // Runs one instruction from FETCH, fd/md = non-ready cycles before mem_ready
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input bit z, input int fd, input int md, input string nm);
        cls_t c;
        bit   rdy;
        bit   exp_pcw;
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        zero   = z;
        c = ref_class(op, f3, f7);
        for (int i = 0; i < TO && i <= fd; i++) begin
            rdy = (i == fd);
            mem_ready = rdy;
            #1;
            chk({nm, "/fetch_state"}, state, 0);
            chk({nm, "/fetch_strobes"}, strobes(), {1'b1, 1'b0, rdy, rdy, 2'b00});
            chk({nm, "/fetch_srcb"}, alu_src_b, 2);
            chk({nm, "/fetch_aluop"}, alu_op, 0);
            tick();
        end
        if (fd >= TO) begin
            expect_trap({nm, "/fetch_to"}, 1'b1);
            return;
        end
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk({nm, "/decode_state"}, state, 1);
        chk({nm, "/decode_strobes"}, strobes(), 6'b000000);
        tick();
        if (c == C_BAD) begin
            expect_trap({nm, "/illegal"}, 1'b0);
            return;
        end
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        exp_pcw = (c == C_JAL) || (c == C_BR && ((f3 == 0) ? z : !z));
        chk({nm, "/exec_state"}, state, 2);
        chk({nm, "/exec_strobes"}, strobes(), {3'b000, exp_pcw, 2'b00});
        if (c != C_JAL) chk({nm, "/exec_aluop"}, alu_op, ref_alu(c, f3, f7));
        if (c == C_R || c == C_BR) chk({nm, "/exec_srcb"}, alu_src_b, 0);
        if (c == C_I || c == C_LD || c == C_ST) chk({nm, "/exec_srcb"}, alu_src_b, 1);
        if (c == C_R || c == C_LD || c == C_ST) chk({nm, "/exec_srca"}, alu_src_a, 1);
        tick();
        if (c == C_LD || c == C_ST) begin
            for (int i = 0; i < TO && i <= md; i++) begin
                rdy = (i == md);
                mem_ready = rdy;
                #1;
                chk({nm, "/mem_state"}, state, 3);
                chk({nm, "/mem_strobes"}, strobes(), {c == C_LD, c == C_ST, 4'b0000});
                tick();
            end
            if (md >= TO) begin
                expect_trap({nm, "/mem_to"}, 1'b1);
                return;
            end
        end
        if (c == C_R || c == C_I || c == C_LD || c == C_JAL) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk({nm, "/wb_state"}, state, 4);
            chk({nm, "/wb_strobes"}, strobes(), {4'b0000, 1'b1, c == C_LD});
            tick();
        end
        mem_ready = 1'b0;
    endtask

    function automatic int rand_delay();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return TO;
        if (r == 1) return TO - 1;
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [6:0] op, f7;
        logic [2:0] f3;
        int         kind;
        rst = 1'b1;
        opcode = 7'b0; funct3 = 3'b0; funct7 = 7'b0; zero = 1'b0; mem_ready = 1'b0;
        do_reset();

        // Directed scenarios
        run_instr(7'b0110011, 3'b000, 7'h00, 1'b0, 0, 0, "add");
        run_instr(7'b0110011, 3'b000, 7'h20, 1'b0, 1, 0, "sub");
        run_instr(7'b0000011, 3'b010, 7'h00, 1'b0, 0, 3, "lw_d3");
        run_instr(7'b0100011, 3'b010, 7'h00, 1'b0, 0, 2, "sw");
        run_instr(7'b1100011, 3'b001, 7'h00, 1'b0, 0, 0, "bne_z0");
        run_instr(7'b1100011, 3'b000, 7'h00, 1'b0, 0, 0, "beq_z0");
        run_instr(7'b1100011, 3'b000, 7'h00, 1'b1, 0, 0, "beq_z1");
        run_instr(7'b1101111, 3'b000, 7'h00, 1'b0, 0, 0, "jal");
        run_instr(7'b0010011, 3'b101, 7'h20, 1'b0, 0, 0, "srai");
        run_instr(7'b0010011, 3'b100, 7'h55, 1'b0, 0, 0, "xori");
        run_instr(7'b0110011, 3'b011, 7'h00, 1'b0, 0, 0, "sltu");
        run_instr(7'b1111111, 3'b000, 7'h00, 1'b0, 0, 0, "bad_op");
        run_instr(7'b0110011, 3'b001, 7'h00, 1'b0, TO, 0, "fetch_to16");
        run_instr(7'b0110011, 3'b001, 7'h00, 1'b0, TO - 1, 0, "fetch_rdy16");
        run_instr(7'b0000011, 3'b010, 7'h00, 1'b0, 0, TO, "lw_to16");
        run_instr(7'b0100011, 3'b010, 7'h00, 1'b0, 0, TO - 1, "sw_rdy16");

        // Reset in the middle of a stalled store
        opcode = 7'b0100011; funct3 = 3'b010; funct7 = 7'h00;
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0; tick();
        tick();
        tick();
        tick();
        chk("midrst/mem_state", state, 3);
        chk("midrst/mem_write", mem_write, 1);
        rst = 1'b1;
        tick();
        chk("midrst/state", state, 0);
        chk("midrst/mem_write_off", mem_write, 0);
        rst = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            mem_ready = 1'b0;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("midrst/ir_write_last", ir_write, 1);
        tick();
        chk("midrst/cnt_cleared", state, 1);
        mem_ready = 1'b0;
        do_reset();

        // Random instruction stream
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 7));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            case (kind)
                0, 7:    op = 7'b0110011;
                1:       op = 7'b0010011;
                2:       begin op = 7'b0000011; if ($urandom_range(0, 3) != 0) f3 = 3'b010; end
                3:       begin op = 7'b0100011; if ($urandom_range(0, 3) != 0) f3 = 3'b010; end
                4:       begin op = 7'b1100011; if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1)); end
                5:       op = 7'b1101111;
                default: op = 7'($urandom_range(0, 127));
            endcase
            run_instr(op, f3, f7, 1'($urandom_range(0, 1)), rand_delay(), rand_delay(), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
